count_monitor: RTL and testbench

- Consumer stage in the clk2 domain, fed by the two-flop synchronised counter value.
- The counter value is synchronised bit-by-bit without gray coding, so a sampled word can be briefly incoherent.
- This block filters the value: a value is accepted only after it has been stable for a programmable number of cycles.
- It then detects threshold crossings and wrap-arounds, and raises a sticky interrupt with an acknowledge handshake.

---
 rtl/count_monitor.sv | 152 +++++++++++++++
 tb/tb_count_monitor.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/count_monitor.sv
// count_monitor
//   Consumer stage in the clk2 domain for a counter value that was synchronised
//   bit-by-bit, without gray coding. Because each bit is synchronised on its
//   own, a sampled word can be briefly incoherent. The block therefore accepts
//   a value only after it has been stable for STABLE_P consecutive samples.
//   On the accepted value it detects threshold crossings and wrap-arounds, and
//   it raises a sticky interrupt that is cleared by an acknowledge pulse.
//
// Ports
//   clk2         in   destination-domain clock; all logic uses its rising edge
//   reset        in   synchronous, active-high reset
//   val_in       in   synchronised counter value (WIDTH_P)
//   thresh       in   threshold (WIDTH_P); quasi-static
//   thresh_en    in   enables the threshold compare
//   irq_ack      in   single-cycle pulse that clears irq_cause
//   val_stable   out  last accepted value (WIDTH_P)
//   stable_vld   out  at least one value has been accepted since reset
//   above_thresh out  registered threshold compare result
//   wrap_cnt     out  saturating count of wrap events (WRAPCNT_W)
//   irq_cause    out  sticky causes: bit0 = threshold rise, bit1 = wrap
//   irq          out  OR of the irq_cause bits
module count_monitor #(
  parameter int WIDTH_P   = 4,
  parameter int STABLE_P  = 2,
  parameter int WRAPCNT_W = 8
) (
  input  logic                 clk2,
  input  logic                 reset,
  input  logic [WIDTH_P-1:0]   val_in,
  input  logic [WIDTH_P-1:0]   thresh,
  input  logic                 thresh_en,
  input  logic                 irq_ack,
  output logic [WIDTH_P-1:0]   val_stable,
  output logic                 stable_vld,
  output logic                 above_thresh,
  output logic [WRAPCNT_W-1:0] wrap_cnt,
  output logic [1:0]           irq_cause,
  output logic                 irq
);

  // The stability counter must be able to hold STABLE_P itself.
  localparam int CNT_W = (STABLE_P < 1) ? 1 : $clog2(STABLE_P + 1);
  localparam logic [CNT_W-1:0]     STAB_MAX    = CNT_W'(STABLE_P);
  localparam logic [CNT_W-1:0]     STAB_COMMIT = CNT_W'(STABLE_P - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WRAPCNT_W-1:0] WRAP_ONE    = {{(WRAPCNT_W-1){1'b0}}, 1'b1};
  localparam logic [WRAPCNT_W-1:0] WRAP_SAT    = {WRAPCNT_W{1'b1}};

  logic [WIDTH_P-1:0]   val_q_r;
  logic [CNT_W-1:0]     stab_cnt_r;
  logic [WIDTH_P-1:0]   val_stable_r;
  logic                 stable_vld_r;
  logic                 above_thresh_r;
  logic                 above_prev_r;
  logic [WRAPCNT_W-1:0] wrap_cnt_r;
  logic [1:0]           irq_cause_r;
  logic                 irq_r;

  logic                 match_s;
  logic [CNT_W-1:0]     stab_cnt_nxt_s;
  logic                 commit_s;
  logic                 wrap_s;
  logic                 above_nxt_s;
  logic                 rise_s;
  logic [WRAPCNT_W-1:0] wrap_cnt_nxt_s;
  logic [1:0]           irq_cause_nxt_s;

  // Next-state logic for the filter, the event detectors and the cause register.
  always_comb begin
    match_s         = (val_in == val_q_r);
    stab_cnt_nxt_s  = {CNT_W{1'b0}};
    commit_s        = 1'b0;
    wrap_s          = 1'b0;
    above_nxt_s     = 1'b0;
    rise_s          = 1'b0;
    wrap_cnt_nxt_s  = wrap_cnt_r;
    irq_cause_nxt_s = irq_cause_r;

    if (match_s) begin
      if (stab_cnt_r != STAB_MAX) begin
        stab_cnt_nxt_s = stab_cnt_r + CNT_ONE;
      end else begin
        stab_cnt_nxt_s = stab_cnt_r;
      end
    end else begin
      stab_cnt_nxt_s = {CNT_W{1'b0}};
    end

    // Commit only on the step into saturation, so a held value commits once.
    commit_s = match_s && (stab_cnt_r == STAB_COMMIT);
    // A newly accepted value below the previous one is a wrap; the first
    // commit after reset has no previous value to compare against.
    wrap_s   = commit_s && stable_vld_r && (val_q_r < val_stable_r);

    above_nxt_s = stable_vld_r && thresh_en && (val_stable_r >= thresh);
    // Rising edge of the registered compare, judged against its previous value.
    rise_s      = above_thresh_r && !above_prev_r;

    if (wrap_s && (wrap_cnt_r != WRAP_SAT)) begin
      wrap_cnt_nxt_s = wrap_cnt_r + WRAP_ONE;
    end else begin
      wrap_cnt_nxt_s = wrap_cnt_r;
    end

    // Ack clears first, then new events are OR-ed in: set wins over clear.
    if (irq_ack) begin
      irq_cause_nxt_s = 2'b00;
    end else begin
      irq_cause_nxt_s = irq_cause_r;
    end
    irq_cause_nxt_s = irq_cause_nxt_s | {wrap_s, rise_s};
  end

  // State registers; reset has priority over every other update.
  always_ff @(posedge clk2) begin
    if (reset) begin
      val_q_r        <= {WIDTH_P{1'b0}};
      stab_cnt_r     <= {CNT_W{1'b0}};
      val_stable_r   <= {WIDTH_P{1'b0}};
      stable_vld_r   <= 1'b0;
      above_thresh_r <= 1'b0;
      above_prev_r   <= 1'b0;
      wrap_cnt_r     <= {WRAPCNT_W{1'b0}};
      irq_cause_r    <= 2'b00;
      irq_r          <= 1'b0;
    end else begin
      val_q_r        <= val_in;
      stab_cnt_r     <= stab_cnt_nxt_s;
      if (commit_s) begin
        val_stable_r <= val_q_r;
        stable_vld_r <= 1'b1;
      end else begin
        val_stable_r <= val_stable_r;
        stable_vld_r <= stable_vld_r;
      end
      above_thresh_r <= above_nxt_s;
      above_prev_r   <= above_thresh_r;
      wrap_cnt_r     <= wrap_cnt_nxt_s;
      irq_cause_r    <= irq_cause_nxt_s;
      // Registered copy of the OR of the next causes, equal to OR of irq_cause.
      irq_r          <= |irq_cause_nxt_s;
    end
  end

  assign val_stable   = val_stable_r;
  assign stable_vld   = stable_vld_r;
  assign above_thresh = above_thresh_r;
  assign wrap_cnt     = wrap_cnt_r;
  assign irq_cause    = irq_cause_r;
  assign irq          = irq_r;

endmodule

// File: tb/tb_count_monitor.sv
// tb_count_monitor
//   Directed bench for count_monitor (WIDTH_P=4, STABLE_P=2, WRAPCNT_W=8).
//   Expected output states are pushed to a scoreboard queue when the stimulus
//   for a cycle is driven, and popped and compared after the next clock edge.
module tb_count_monitor;

  logic       clk2 = 1'b0;
  logic       reset;
  logic [3:0] val_in;
  logic [3:0] thresh;
  logic       thresh_en;
  logic       irq_ack;
  logic [3:0] val_stable;
  logic       stable_vld;
  logic       above_thresh;
  logic [7:0] wrap_cnt;
  logic [1:0] irq_cause;
  logic       irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [3:0] vs;
    logic       vld;
    logic       ab;
    logic [7:0] wc;
    logic [1:0] cause;
    logic       irq;
  } exp_t;

  exp_t sb[$];

  count_monitor #(
    .WIDTH_P  (4),
    .STABLE_P (2),
    .WRAPCNT_W(8)
  ) dut (
    .clk2        (clk2),
    .reset       (reset),
    .val_in      (val_in),
    .thresh      (thresh),
    .thresh_en   (thresh_en),
    .irq_ack     (irq_ack),
    .val_stable  (val_stable),
    .stable_vld  (stable_vld),
    .above_thresh(above_thresh),
    .wrap_cnt    (wrap_cnt),
    .irq_cause   (irq_cause),
    .irq         (irq)
  );

  always #5 clk2 = ~clk2;

  task automatic chk(input string tag, input string field, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s.%s observed %0h expected %0h", tag, field, got, exp);
    end
  endtask

  // Expectation for the state after the next edge.
  task automatic expect_state(input string tag, input logic [3:0] vs, input logic vld, input logic ab,
                              input logic [7:0] wc, input logic [1:0] cause, input logic ir);
    exp_t e;
    e.tag = tag; e.vs = vs; e.vld = vld; e.ab = ab; e.wc = wc; e.cause = cause; e.irq = ir;
    sb.push_back(e);
  endtask

  // One clock; outputs sampled 1 time unit after the edge, queue drained.
  task automatic tick();
    exp_t e;
    @(posedge clk2);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, "val_stable",   8'(val_stable),   8'(e.vs));
      chk(e.tag, "stable_vld",   8'(stable_vld),   8'(e.vld));
      chk(e.tag, "above_thresh", 8'(above_thresh), 8'(e.ab));
      chk(e.tag, "wrap_cnt",     wrap_cnt,         e.wc);
      chk(e.tag, "irq_cause",    8'(irq_cause),    8'(e.cause));
      chk(e.tag, "irq",          8'(irq),          8'(e.irq));
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset = 1'b1; val_in = 4'd0; thresh = 4'd0; thresh_en = 1'b0; irq_ack = 1'b0;
    ticks(1);
    expect_state("reset", 4'd0, 1'b0, 1'b0, 8'd0, 2'b00, 1'b0);
    tick();

    // First value: visible three edges after it is presented.
    reset = 1'b0; val_in = 4'd5;
    expect_state("first_c1", 4'd0, 1'b0, 1'b0, 8'd0, 2'b00, 1'b0); tick();
    expect_state("first_c2", 4'd0, 1'b0, 1'b0, 8'd0, 2'b00, 1'b0); tick();
    expect_state("first_c3", 4'd5, 1'b1, 1'b0, 8'd0, 2'b00, 1'b0); tick();

    // One-cycle glitch must not be accepted.
    ticks(2);
    val_in = 4'd7; tick();
    val_in = 4'd5;
    expect_state("glitch_a", 4'd5, 1'b1, 1'b0, 8'd0, 2'b00, 1'b0); tick();
    tick();
    expect_state("glitch_b", 4'd5, 1'b1, 1'b0, 8'd0, 2'b00, 1'b0); tick();
    expect_state("glitch_c", 4'd5, 1'b1, 1'b0, 8'd0, 2'b00, 1'b0); tick();

    // Wrap 14 -> 15 -> 1.
    val_in = 4'd14; ticks(2);
    expect_state("acc14", 4'd14, 1'b1, 1'b0, 8'd0, 2'b00, 1'b0); tick();
    val_in = 4'd15; ticks(2);
    expect_state("acc15", 4'd15, 1'b1, 1'b0, 8'd0, 2'b00, 1'b0); tick();
    val_in = 4'd1; tick();
    expect_state("pre_wrap", 4'd15, 1'b1, 1'b0, 8'd0, 2'b00, 1'b0); tick();
    expect_state("wrap1", 4'd1, 1'b1, 1'b0, 8'd1, 2'b10, 1'b1); tick();
    irq_ack = 1'b1;
    expect_state("ack1", 4'd1, 1'b1, 1'b0, 8'd1, 2'b00, 1'b0); tick();
    irq_ack = 1'b0; tick();
    irq_ack = 1'b1;
    expect_state("ack_idle", 4'd1, 1'b1, 1'b0, 8'd1, 2'b00, 1'b0); tick();
    irq_ack = 1'b0;

    // 299 more wraps: counter saturates at 255.
    for (int i = 0; i < 299; i++) begin
      val_in = 4'd9; ticks(3);
      val_in = 4'd2; ticks(3);
    end
    expect_state("wrap_sat", 4'd2, 1'b1, 1'b0, 8'd255, 2'b10, 1'b1); tick();
    irq_ack = 1'b1;
    expect_state("ack_sat", 4'd2, 1'b1, 1'b0, 8'd255, 2'b00, 1'b0); tick();
    irq_ack = 1'b0;

    // Threshold ramp 6, 7, 8 against thresh 8.
    thresh = 4'd8; thresh_en = 1'b1;
    expect_state("th_low", 4'd2, 1'b1, 1'b0, 8'd255, 2'b00, 1'b0); tick();
    val_in = 4'd6; ticks(3);
    val_in = 4'd7; ticks(2);
    expect_state("th_7", 4'd7, 1'b1, 1'b0, 8'd255, 2'b00, 1'b0); tick();
    val_in = 4'd8; ticks(2);
    expect_state("th_8_lag", 4'd8, 1'b1, 1'b0, 8'd255, 2'b00, 1'b0); tick();
    expect_state("th_above", 4'd8, 1'b1, 1'b1, 8'd255, 2'b00, 1'b0); tick();
    expect_state("th_cause", 4'd8, 1'b1, 1'b1, 8'd255, 2'b01, 1'b1); tick();
    thresh_en = 1'b0;
    expect_state("th_dis", 4'd8, 1'b1, 1'b0, 8'd255, 2'b01, 1'b1); tick();
    expect_state("th_fall", 4'd8, 1'b1, 1'b0, 8'd255, 2'b01, 1'b1); tick();
    irq_ack = 1'b1;
    expect_state("th_ack", 4'd8, 1'b1, 1'b0, 8'd255, 2'b00, 1'b0); tick();
    irq_ack = 1'b0; thresh_en = 1'b1;
    expect_state("th_reen", 4'd8, 1'b1, 1'b1, 8'd255, 2'b00, 1'b0); tick();
    expect_state("th_cause2", 4'd8, 1'b1, 1'b1, 8'd255, 2'b01, 1'b1); tick();

    // Wrap commit on the same edge as irq_ack: wrap cause set, threshold cleared.
    val_in = 4'd3; ticks(2);
    irq_ack = 1'b1;
    expect_state("ack_vs_wrap", 4'd3, 1'b1, 1'b1, 8'd255, 2'b10, 1'b1); tick();
    irq_ack = 1'b0;
    expect_state("after_sim", 4'd3, 1'b1, 1'b0, 8'd255, 2'b10, 1'b1); tick();

    // Reset mid-operation, then three wraps including a drop to 0.
    thresh_en = 1'b0; reset = 1'b1;
    expect_state("reset2", 4'd0, 1'b0, 1'b0, 8'd0, 2'b00, 1'b0); tick();
    reset = 1'b0;
    val_in = 4'd10; ticks(2);
    expect_state("acc10", 4'd10, 1'b1, 1'b0, 8'd0, 2'b00, 1'b0); tick();
    val_in = 4'd12; ticks(3); val_in = 4'd4; ticks(3);
    val_in = 4'd12; ticks(3); val_in = 4'd0; ticks(2);
    expect_state("wrap_zero", 4'd0, 1'b1, 1'b0, 8'd2, 2'b10, 1'b1); tick();
    val_in = 4'd12; ticks(3); val_in = 4'd4; ticks(2);
    expect_state("wrap3", 4'd4, 1'b1, 1'b0, 8'd3, 2'b10, 1'b1); tick();
    val_in = 4'd9; ticks(2);
    reset = 1'b1;
    expect_state("reset3", 4'd0, 1'b0, 1'b0, 8'd0, 2'b00, 1'b0); tick();
    reset = 1'b0; val_in = 4'd2;
    expect_state("post_c1", 4'd0, 1'b0, 1'b0, 8'd0, 2'b00, 1'b0); tick();
    expect_state("post_c2", 4'd0, 1'b0, 1'b0, 8'd0, 2'b00, 1'b0); tick();
    expect_state("post_c3", 4'd2, 1'b1, 1'b0, 8'd0, 2'b00, 1'b0); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
